alu_bool_issuer: RTL and testbench
==================================

# alu_bool_issuer

Sequencing front end for the `alu_bool` slice. Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. Drives each command onto the slice's `A`/`B`/`opcode`/`en` inputs for exactly one cycle, registers the slice's combinational `result`, and returns it over a valid/ready response interface. It sits between the instruction-dispatch logic and the slice, and is the only block that drives the slice's `en`.

## Interface
- `WIDTH`, 16: operand and result width; matches the slice.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: FIFO can accept; equals registered `count < DEPTH`.
- `cmd_a`, `cmd_b` input WIDTH: operands.
- `cmd_opcode` input 4: operation code.
- `alu_a`, `alu_b` output WIDTH: to slice `A`, `B`.
- `alu_opcode` output 4: to slice `opcode`.
- `alu_en` output 1: to slice `en`.
- `alu_result` input WIDTH: from slice `result` (combinational).
- `rsp_valid` output 1: response held.
- `rsp_ready` input 1: consumer accepts.
- `rsp_result` output WIDTH: captured result.
- `rsp_opcode` output 4: opcode of the responding command.
- `rsp_err` output 1: illegal opcode flag (see Configuration).
- `busy` output 1: `state != IDLE || count != 0`.

## Operation
- Command handshake: a push occurs on an edge where `cmd_valid && cmd_ready`. `{cmd_a, cmd_b, cmd_opcode}` is written at `wr_ptr`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is `$clog2(DEPTH+1)` bits.
- Push and pop on the same edge leave `count` unchanged.
- `cmd_ready` is computed from the registered `count`. When full, a same-cycle pop does not enable a push.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE → ISSUE when `count != 0`: pop the head into the issue registers (`alu_a`, `alu_b`, `alu_opcode`).
  - ISSUE → RESP, unconditionally after one cycle. `alu_en = 1` only in ISSUE. At the closing edge, latch `alu_result` to `rsp_result` and `alu_opcode` to `rsp_opcode`, and set `rsp_valid`.
  - RESP: hold all `rsp_*` outputs stable while `rsp_valid && !rsp_ready`.
    - On `rsp_ready` with `count != 0`: pop and go to ISSUE (back-to-back).
    - On `rsp_ready` with `count == 0`: go to IDLE.
    - `rsp_valid` clears at the edge where the response is accepted.
- Outside ISSUE, `alu_a`, `alu_b` and `alu_opcode` hold their last issued values and `alu_en = 0`.
- Supported opcodes: `4'b0100` (compare) and `4'b0101` (NOR). The block does not interpret results; it captures the slice output verbatim.
- Reset values: `cmd_ready = 1` (FIFO empty); `alu_a = alu_b = 0`; `alu_opcode = 0`; `alu_en = 0`; `rsp_valid = 0`; `rsp_result = 0`; `rsp_opcode = 0`; `rsp_err = 0`; `busy = 0`; state IDLE; pointers and `count` 0.
- Reset asserted mid-operation:
  - Queued and in-flight commands are discarded.
  - `alu_en` drops immediately (asynchronous).
  - No response is produced for discarded commands.

## Timing
- Latency, empty pipe: push at edge E0 → IDLE→ISSUE at E1 → `alu_en` high in the cycle E1–E2 → `rsp_valid` high after E2.
- Throughput: one command per 2 cycles when `rsp_ready` is held high.
- `alu_en` is high for exactly one cycle per command, never two consecutive cycles.
- A push at E0 is never visible to the FSM before E1; the FIFO has no bypass path.
- A stalled response (`rsp_ready = 0`) blocks issue. The FIFO keeps accepting commands until `count == DEPTH`.

## Configuration
- `ALU_ISSUER_OPCHECK_EN` defined:
  - An opcode other than `0100` or `0101` still passes through ISSUE for one cycle, but with `alu_en = 0`.
  - Its response carries `rsp_result = 0` and `rsp_err = 1`.
  - Legal opcodes carry `rsp_err = 0`.
- `ALU_ISSUER_OPCHECK_EN` undefined:
  - Every opcode is issued with `alu_en = 1`.
  - `rsp_err` is tied to 0.

## Test plan
- Single NOR: push A=0x00F0, B=0x0F00, op=0101 with `rsp_ready = 1` → `alu_en` high for one cycle at E1–E2; `rsp_valid` after E2 with `rsp_result = 0xF00F`, `rsp_opcode = 0101`.
- Fill and backpressure: hold `rsp_ready = 0` and push 6 commands →
  - 1 command issues into RESP and 4 fill the FIFO, after which `cmd_ready` goes 0 and the 6th push stalls.
  - Releasing `rsp_ready` drains all 6 in order, with `alu_en` pulses exactly 2 cycles apart.
- Pointer wrap: stream 3×DEPTH compare ops with A=B=i (expected result 1) and A≠B (expected result 0), alternating → responses match in order.
- Simultaneous push/pop at `count = 2`: `count` stays 2 and no entry is lost or duplicated.
- Reset mid-ISSUE with 3 entries queued → `alu_en`, `rsp_valid`, `busy` = 0 at once; after release, `cmd_ready = 1` and no stale response appears.
- Opcode check: op=0111, A=B=0xFFFF →
  - With `ALU_ISSUER_OPCHECK_EN`: `alu_en` stays 0; response has `rsp_result = 0`, `rsp_err = 1`.
  - Without it: `alu_en` pulses once; response has `rsp_err = 0`.

Source files
------------

// File: rtl/alu_bool_issuer.sv
// alu_bool_issuer: command FIFO plus a one-shot issue FSM that drives the alu_bool slice and returns its result.
// Optional feature macro ALU_ISSUER_OPCHECK_EN: illegal opcodes are issued with en low and answered with rsp_err.
module alu_bool_issuer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_opcode,
  output logic             rsp_err,
  output logic             busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * WIDTH + 4;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_r;
  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] head_s;
  logic          head_en_s;

`ifdef ALU_ISSUER_OPCHECK_EN
  function automatic logic op_legal(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0101);
  endfunction
`endif

  assign cmd_ready = (count_r < CNT_FULL);
  assign busy      = (state_r != IDLE) || (count_r != '0);
  assign head_s    = mem_r[rd_ptr_r];

  // Handshake decode; pops only happen when the FSM is free to take a new command.
  always_comb begin
    push_s    = cmd_valid && cmd_ready;
    pop_s     = 1'b0;
    head_en_s = 1'b1;
    if (count_r != '0) begin
      if (state_r == IDLE) begin
        pop_s = 1'b1;
      end else if ((state_r == RESP) && rsp_ready) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
`ifdef ALU_ISSUER_OPCHECK_EN
    head_en_s = op_legal(head_s[3:0]);
`else
    head_en_s = 1'b1;
`endif
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd_a, cmd_b, cmd_opcode};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue/response FSM; the async reset also drops alu_en immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 4'b0000;
      alu_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_opcode <= 4'b0000;
      rsp_err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            {alu_a, alu_b, alu_opcode} <= head_s;
            alu_en  <= head_en_s;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          alu_en     <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_opcode <= alu_opcode;
`ifdef ALU_ISSUER_OPCHECK_EN
          rsp_result <= op_legal(alu_opcode) ? alu_result : '0;
          rsp_err    <= !op_legal(alu_opcode);
`else
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
`endif
          state_r    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop_s) begin
              {alu_a, alu_b, alu_opcode} <= head_s;
              alu_en  <= head_en_s;
              state_r <= ISSUE;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          alu_en  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bool_issuer.sv
// Scoreboard bench for alu_bool_issuer with a behavioural alu_bool slice stub.
module tb_alu_bool_issuer;
  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_en;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_opcode;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [20:0] sb_q[$];
  int en_cycles[$];
  logic prev_en = 1'b0;

  alu_bool_issuer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_en(alu_en),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_opcode(rsp_opcode), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] slice_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    case (op)
      4'b0100: slice_fn = (a == b) ? 16'd1 : 16'd0;
      4'b0101: slice_fn = ~(a | b);
      default: slice_fn = a & b;
    endcase
  endfunction

  always_comb alu_result = slice_fn(alu_a, alu_b, alu_opcode);

  // expected response word: {err, opcode, result}
  function automatic logic [20:0] exp_rsp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
`ifdef ALU_ISSUER_OPCHECK_EN
    if (op != 4'b0100 && op != 4'b0101) return {1'b1, op, 16'h0000};
`endif
    return {1'b0, op, slice_fn(a, b, op)};
  endfunction

  // Response monitor: sampled 1 time unit after the falling edge, i.e. well before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (alu_en) begin
          checks++;
          if (prev_en) begin
            failures++;
            $display("FAIL en_single_cycle: alu_en high two cycles in a row at cycle %0d (required one cycle)", cyc);
          end
          en_cycles.push_back(cyc);
        end
        prev_en = alu_en;
        if (rsp_valid && rsp_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rsp: got err=%0b op=%h res=%h, required no response", rsp_err, rsp_opcode, rsp_result);
          end else begin
            logic [20:0] e;
            e = sb_q.pop_front();
            if ({rsp_err, rsp_opcode, rsp_result} !== e) begin
              failures++;
              $display("FAIL rsp_data: got err=%0b op=%h res=%h, required err=%0b op=%h res=%h",
                       rsp_err, rsp_opcode, rsp_result, e[20], e[19:16], e[15:0]);
            end
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic do_push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_opcode = op;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: cmd_ready=0 after %0d cycles, required 1", n);
    end else begin
      sb_q.push_back(exp_rsp(a, b, op));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (sb_q.size() == 0) && !busy;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL rst_alu_en: got %b required 0", alu_en); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if ({alu_a, alu_b, alu_opcode} !== 36'h0) begin failures++; $display("FAIL rst_alu_regs: got %h required 0", {alu_a, alu_b, alu_opcode}); end
    checks++; if ({rsp_err, rsp_opcode, rsp_result} !== 21'h0) begin failures++; $display("FAIL rst_rsp_regs: got %h required 0", {rsp_err, rsp_opcode, rsp_result}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_nor;
    bit ok;
    rsp_ready = 1'b1;
    do_push(16'h00F0, 16'h0F00, 4'b0101);
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL nor_no_bypass: alu_en=%b after E0, required 0", alu_en); end
    @(negedge clk);
    checks++; if (alu_en !== 1'b1) begin failures++; $display("FAIL nor_en_e1: alu_en=%b, required 1", alu_en); end
    checks++; if ({alu_a, alu_b, alu_opcode} !== {16'h00F0, 16'h0F00, 4'b0101}) begin
      failures++; $display("FAIL nor_issue_regs: got %h/%h/%h required 00f0/0f00/5", alu_a, alu_b, alu_opcode); end
    @(negedge clk);
    checks++; if (alu_en !== 1'b0 || rsp_valid !== 1'b1) begin
      failures++; $display("FAIL nor_rsp_timing: alu_en=%b rsp_valid=%b, required 0/1", alu_en, rsp_valid); end
    checks++; if (rsp_result !== 16'hF00F || rsp_opcode !== 4'b0101) begin
      failures++; $display("FAIL nor_rsp_value: got %h op %h required f00f op 5", rsp_result, rsp_opcode); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL nor_drain: %0d responses outstanding, required 0", sb_q.size()); end
  endtask

  task automatic test_backpressure;
    bit ok;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_push(16'h1000 + 16'(i), 16'h0101 << i, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_full: cmd_ready=%b, required 0", cmd_ready); end
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold: rsp_valid=%b, required 1", rsp_valid); end
      @(negedge clk);
    end
    en_cycles.delete();
    rsp_ready = 1'b1;
    do_push(16'hABCD, 16'h1234, 4'b0101);
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_drain: %0d responses outstanding, required 0", sb_q.size()); end
    checks++; if (en_cycles.size() != 5) begin failures++; $display("FAIL bp_pulses: got %0d en pulses, required 5", en_cycles.size()); end
    for (int i = 1; i < en_cycles.size(); i++) begin
      checks++;
      if (en_cycles[i] - en_cycles[i-1] != 2) begin
        failures++; $display("FAIL bp_spacing: pulse gap %0d, required 2", en_cycles[i] - en_cycles[i-1]); end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [15:0] v;
      v = 16'(i * 16'h0111 + 3);
      if (i % 2 == 0) do_push(v, v, 4'b0100);
      else do_push(v, ~v, 4'b0100);
    end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain: %0d responses outstanding, required 0", sb_q.size()); end
  endtask

  task automatic test_simul_push_pop;
    bit ok;
    rsp_ready = 1'b0;
    do_push(16'h0001, 16'h0002, 4'b0101);
    do_push(16'h0003, 16'h0004, 4'b0101);
    do_push(16'h0005, 16'h0005, 4'b0100);
    rsp_ready = 1'b1;
    do_push(16'h0007, 16'h0008, 4'b0101);
    rsp_ready = 1'b0;
    do_push(16'h0009, 16'h0009, 4'b0100);
    do_push(16'h000B, 16'h000C, 4'b0101);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL simul_count: cmd_ready=%b after 2 extra pushes, required 0", cmd_ready); end
    rsp_ready = 1'b1;
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL simul_drain: %0d responses outstanding, required 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_push(16'h2000 + 16'(i), 16'h00FF, 4'b0101);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (alu_en !== 1'b1) begin failures++; $display("FAIL rmid_in_issue: alu_en=%b, required 1", alu_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL rmid_alu_en: got %b required 0", alu_en); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b required 0", busy); end
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_cmd_ready: got %b required 1", cmd_ready); end
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rmid_stale: rsp_valid=%b busy=%b, required 0/0", rsp_valid, busy); end
  endtask

  task automatic test_opcheck;
    bit ok;
    int exp_pulses;
`ifdef ALU_ISSUER_OPCHECK_EN
    exp_pulses = 0;
`else
    exp_pulses = 1;
`endif
    rsp_ready = 1'b1;
    en_cycles.delete();
    do_push(16'hFFFF, 16'hFFFF, 4'b0111);
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL opchk_drain: %0d responses outstanding, required 0", sb_q.size()); end
    checks++; if (en_cycles.size() != exp_pulses) begin
      failures++; $display("FAIL opchk_en: got %0d en pulses, required %0d", en_cycles.size(), exp_pulses); end
    en_cycles.delete();
    do_push(16'h00FF, 16'h00FF, 4'b0100);
    drain(ok);
    checks++; if (!ok || en_cycles.size() != 1) begin
      failures++; $display("FAIL opchk_legal: drained=%0b pulses=%0d, required 1/1", ok, en_cycles.size()); end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_a = 16'h0000;
    cmd_b = 16'h0000;
    cmd_opcode = 4'b0000;
    rsp_ready = 1'b0;
    test_reset();
    test_single_nor();
    test_backpressure();
    test_wrap();
    test_simul_push_pop();
    test_reset_mid();
    test_opcheck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
